// File: rtl/tmiv_evfifo_pkg.sv
// tmiv_evfifo_pkg: shared LFSR pointer sequence and buffer depth
package tmiv_evfifo_pkg;
  localparam logic [3:0] lfsr_init = 4'b0001;
  localparam int depth = 15;
  function automatic logic [3:0] lfsr_next(input logic [3:0] p);
    return {p[2:1], p[3] ^ p[0], p[3]};
  endfunction
endpackage

// File: rtl/tmiv_evfifo_lfsr4_ptr.sv
// lfsr4_ptr: 4-bit maximal-length LFSR pointer, advances on adv
module lfsr4_ptr
  import tmiv_evfifo_pkg::*;
(
  input  logic       hsclkp,
  input  logic       _rst,
  input  logic       adv,
  output logic [3:0] p
);
  always_ff @(posedge hsclkp or negedge _rst)
    if (!_rst) p <= lfsr_init;
    else if (adv) p <= lfsr_next(p);
endmodule

// File: rtl/tmiv_evfifo.sv
// tmiv_evfifo: 15-deep first-word-fall-through event buffer with full/drop/level flags
module tmiv_evfifo
  import tmiv_evfifo_pkg::*;
#(
  parameter int dsize = 7
) (
  input  logic             hsclkp,
  input  logic             _rst,
  input  logic [dsize-1:0] a,
  input  logic             wr,
  input  logic             rd,
  output logic [dsize-1:0] y,
  output logic             _empty,
  output logic             full,
  output logic             drop,
  output logic [3:0]       lvl
);
  logic [dsize-1:0] mem [1:depth];
  logic [3:0] wp, rp, lvl_n;
  logic wa, ra;
  assign wa = wr && !full;
  assign ra = rd && _empty;
  assign lvl_n = (wa && !ra) ? lvl + 4'd1 : (ra && !wa) ? lvl - 4'd1 : lvl;
  assign y = mem[rp];
  lfsr4_ptr u_wp (.hsclkp(hsclkp), ._rst(_rst), .adv(wa), .p(wp));
  lfsr4_ptr u_rp (.hsclkp(hsclkp), ._rst(_rst), .adv(ra), .p(rp));
  always_ff @(posedge hsclkp)
    if (wa) mem[wp] <= a;
  always_ff @(posedge hsclkp or negedge _rst)
    if (!_rst) begin
      lvl <= 4'd0;
      _empty <= 1'b0;
      full <= 1'b0;
      drop <= 1'b0;
    end else begin
      lvl <= lvl_n;
      _empty <= lvl_n != 4'd0;
      full <= lvl_n == 4'(depth);
      drop <= wr && full;
    end
endmodule

// File: tb/tb_tmiv_evfifo.sv
// tb_tmiv_evfifo: directed and random stimulus against a queue-based reference
module tb_tmiv_evfifo;
  logic hsclkp = 0, _rst = 0, wr = 0, rd = 0;
  logic [6:0] a = 0, y;
  logic _empty, full, drop;
  logic [3:0] lvl;
  int checks = 0, errors = 0;
  logic [6:0] q[$];
  logic exp_drop = 0;

  tmiv_evfifo dut (.hsclkp(hsclkp), ._rst(_rst), .a(a), .wr(wr), .rd(rd), .y(y),
                   ._empty(_empty), .full(full), .drop(drop), .lvl(lvl));

  always #5 hsclkp = ~hsclkp;

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic chk_all(input string tag);
    chk({tag, ".lvl"}, {4'd0, lvl}, 8'(q.size()));
    chk({tag, ".nempty"}, {7'd0, _empty}, {7'd0, q.size() != 0});
    chk({tag, ".full"}, {7'd0, full}, {7'd0, q.size() == 15});
    chk({tag, ".drop"}, {7'd0, drop}, {7'd0, exp_drop});
    if (q.size() != 0) chk({tag, ".y"}, {1'b0, y}, {1'b0, q[0]});
  endtask

  task automatic step(input string tag, input logic w, input logic r, input logic [6:0] d);
    int n;
    wr = w; rd = r; a = d;
    @(posedge hsclkp);
    #1;
    n = q.size();
    exp_drop = w && n == 15;
    if (r && n > 0) void'(q.pop_front());
    if (w && n < 15) q.push_back(d);
    wr = 0; rd = 0;
    chk_all(tag);
  endtask

  initial begin
    #12 chk_all("reset");
    @(negedge hsclkp) _rst = 1;
    step("wr25", 1, 0, 7'h25);
    step("rd25", 0, 1, 7'h00);
    for (int i = 1; i <= 15; i++) step("fill", 1, 0, 7'(i));
    step("wr_full", 1, 0, 7'h10);
    step("drop_clr", 0, 0, 7'h00);
    for (int i = 0; i < 15; i++) step("drain", 0, 1, 7'h00);
    for (int i = 0; i < 3; i++) step("pre3", 1, 0, 7'($urandom));
    for (int i = 0; i < 40; i++) step("wrrd3", 1, 1, 7'($urandom));
    for (int i = 0; i < 12; i++) step("fill2", 1, 0, 7'($urandom));
    step("wrrd15", 1, 1, 7'h55);
    for (int i = 0; i < 14; i++) step("drain2", 0, 1, 7'h00);
    step("wrrd0", 1, 1, 7'h2A);
    step("rd_one", 0, 1, 7'h00);
    for (int i = 0; i < 5; i++) step("rd_empty", 0, 1, 7'h00);
    step("wr7f", 1, 0, 7'h7F);
    step("rd7f", 0, 1, 7'h00);
    for (int i = 0; i < 9; i++) step("pre9", 1, 0, 7'($urandom));
    @(negedge hsclkp);
    _rst = 0;
    #1 q.delete();
    exp_drop = 0;
    chk_all("async_rst");
    @(negedge hsclkp) _rst = 1;
    step("wr11", 1, 0, 7'h11);
    step("rd11", 0, 1, 7'h00);
    for (int i = 0; i < 400; i++)
      step("rand", 1'($urandom_range(0, 99) < 55), 1'($urandom_range(0, 99) < 45), 7'($urandom));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/tmiv_evfifo.md
# tmiv_evfifo

Elastic event buffer in the hsclkp domain of the time-interval measurement path. It sits directly downstream of the interval counter stage and upstream of the toggle-handshake clock-domain crossing. It accepts 7-bit interval words (`{sat, stop, lfsr[3:0], start}`) on a single-cycle strobe and holds up to 15 of them. It presents the oldest word first-word-fall-through, so the crossing logic can launch it without an extra read cycle. It also flags full, drop and occupancy for error reporting.

## Interface
- `dsize`, 7: data word width.
- `hsclkp` input 1: clock; all state on rising edge.
- `_rst` input 1: reset, asynchronous, active-low.
- `a` input dsize: write data.
- `wr` input 1: write strobe, one word per asserted cycle.
- `rd` input 1: read/pop strobe; only honoured when `_empty`=1.
- `y` output dsize: head word (oldest entry); valid while `_empty`=1.
- `_empty` output 1: active-low empty (1 = at least one word held).
- `full` output 1: 15 words held.
- `drop` output 1: one-cycle pulse, a write was refused because `full`=1.
- `lvl` output 4: occupancy 0..15.

## Operation
- Storage: 15 × dsize register array, addressed by 4-bit LFSR pointers `wp` and `rp`.
- Pointer sequence: next = `{p[2:1], p[3]^p[0], p[3]}`, init `4'b0001`, period 15. The cycle is 0001, 0010, 0100, 1000, 0011, 0110, 1100, 1011, 0101, 1010, 0111, 1110, 1111, 1101, 1001. Pointer state `0000` is unreachable.
- Write accepted when `wr`=1 and `full`=0: `mem[wp]<=a`, `wp` advances.
- Read accepted when `rd`=1 and `_empty`=1: `rp` advances. `rd` when empty is ignored, with no pointer or flag change.
- Full and empty are distinguished by `lvl`, a binary up/down counter:
  - +1 on accepted write only.
  - −1 on accepted read only.
  - Unchanged when both or neither are accepted.
- `_empty` = (`lvl`≠0) and `full` = (`lvl`==15), both registered.
- Simultaneous `wr` and `rd` with 1 ≤ `lvl` ≤ 14: both accepted, `lvl` unchanged.
- Simultaneous `wr` and `rd` at `lvl`=15: read accepted, write refused (`drop`=1), and `lvl` becomes 14. Full status is evaluated on the registered flag, with no same-cycle bypass.
- Simultaneous `wr` and `rd` at `lvl`=0: write accepted, read ignored.
- `y` = `mem[rp]`, combinational from registers. Contents are undefined but stable when `_empty`=0.
- `drop` is registered: it is high in the cycle after the refused write.

## Timing
- Reset (async assert, sync-safe deassert by system):
  - `wp`=`rp`=0001 and `lvl`=0.
  - Outputs: `_empty`=0, `full`=0, `drop`=0, `lvl`=0.
  - Memory is not reset; `y` is don't-care while empty.
- Write-to-visible latency: a word written at edge N appears on `y` with `_empty`=1 after edge N (one cycle).
- Read: `rd` sampled at edge N; the next word is on `y` after edge N. If the FIFO empties, `_empty`=0 after edge N.
- Back-to-back reads on consecutive cycles are allowed; the throughput is one word per cycle each way.
- Reset asserted mid-operation: all held words are discarded and every output returns to its reset value immediately (asynchronously).

## Structure
- Shared package holds:
  - The pointer LFSR next-state function and init constant (`4'b0001`), shared with the interval counter.
  - Depth constant 15.
- The natural sub-module is `lfsr4_ptr`: a 4-bit LFSR register with `adv` and init-on-reset. It is instantiated twice, for `wp` and `rp`.
- Everything else stays flat in `tmiv_evfifo`.

## Test plan
- Reset then single write `a`=7'h25, next cycle → `_empty`=1, `y`=7'h25, `lvl`=1. Then `rd` → `_empty`=0 and `lvl`=0 one cycle later.
- Write 15 words 7'h01..7'h0F back-to-back → `full`=1 and `lvl`=15 after the 15th edge. Then a 16th write of 7'h10 → `drop`=1 for one cycle, and contents are unchanged. Reading all 15 yields 01..0F in order.
- Continuous simultaneous `wr`/`rd` for 40 cycles starting at `lvl`=3:
  - `lvl` stays 3 throughout.
  - Data order is preserved across multiple pointer wraps (pointers pass 1001→0001).
- `wr`+`rd` at `lvl`=15 → read accepted, `drop`=1, `lvl`=14, and the head advances. `wr`+`rd` at `lvl`=0 → `lvl`=1 and no underflow.
- `rd` held high while empty for 5 cycles → `rp` unchanged and `lvl`=0. A subsequent write of 7'h7F appears on `y` one cycle later.
- Assert `_rst` mid-stream at `lvl`=9 → `_empty`=0, `full`=0, `lvl`=0 asynchronously. After release, a write of 7'h11 is read back as the first word.
